// File: rtl/alu_issue_stage_pkg.sv
// Shared types and constants for the ALU issue stage: opcodes, funct fields,
// ALU control encoding and the buffered issue packet.
package alu_issue_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [4:0] {
    ALU_CTRL_ADD_ADDI = 5'd0,
    ALU_CTRL_SUB      = 5'd1,
    ALU_CTRL_SLL      = 5'd2,
    ALU_CTRL_SLT      = 5'd3,
    ALU_CTRL_SLTU     = 5'd4,
    ALU_CTRL_XOR      = 5'd5,
    ALU_CTRL_SRL      = 5'd6,
    ALU_CTRL_SRA      = 5'd7,
    ALU_CTRL_OR       = 5'd8,
    ALU_CTRL_AND      = 5'd9,
    ALU_CTRL_LUI      = 5'd10,
    ALU_CTRL_AUIPC    = 5'd11,
    ALU_CTRL_BEQ      = 5'd12,
    ALU_CTRL_BNE      = 5'd13,
    ALU_CTRL_BLT      = 5'd14,
    ALU_CTRL_BGE      = 5'd15,
    ALU_CTRL_BLTU     = 5'd16,
    ALU_CTRL_BGEU     = 5'd17
  } AluControl_t;

  typedef struct packed {
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    AluControl_t      alu_ctrl;
    logic [REG_W-1:0] rd;
    logic             is_branch;
    logic             illegal;
  } issue_pkt_t;

  localparam issue_pkt_t PKT_RESET = '{a: '0, b: '0, alu_ctrl: ALU_CTRL_ADD_ADDI,
                                       rd: '0, is_branch: 1'b0, illegal: 1'b0};

  // Register/immediate arithmetic mapping; alt selects SUB/SRA where defined.
  function automatic AluControl_t arith_ctrl(input logic [2:0] f3, input logic alt);
    AluControl_t c;
    c = ALU_CTRL_ADD_ADDI;
    case (f3)
      F3_ADD_SUB: c = alt ? ALU_CTRL_SUB : ALU_CTRL_ADD_ADDI;
      F3_SLL:     c = ALU_CTRL_SLL;
      F3_SLT:     c = ALU_CTRL_SLT;
      F3_SLTU:    c = ALU_CTRL_SLTU;
      F3_XOR:     c = ALU_CTRL_XOR;
      F3_SRL_SRA: c = alt ? ALU_CTRL_SRA : ALU_CTRL_SRL;
      F3_OR:      c = ALU_CTRL_OR;
      F3_AND:     c = ALU_CTRL_AND;
      default:    c = ALU_CTRL_ADD_ADDI;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream op/operand inputs and downstream EX-side outputs of the issue stage.
interface alu_issue_stage_if;
  import alu_issue_stage_pkg::*;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  instr;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [XLEN-1:0]  imm;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_a;
  logic [XLEN-1:0]  out_b;
  AluControl_t      out_alu_ctrl;
  logic [REG_W-1:0] out_rd;
  logic             out_is_branch;
  logic             out_illegal;

  modport master (
    input  flush, in_valid, instr, pc, rs1_data, rs2_data, imm, out_ready,
    output in_ready, out_valid, out_a, out_b, out_alu_ctrl, out_rd, out_is_branch, out_illegal
  );

  modport slave (
    output flush, in_valid, instr, pc, rs1_data, rs2_data, imm, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_alu_ctrl, out_rd, out_is_branch, out_illegal
  );
endinterface

// File: rtl/alu_issue_stage_alu_ctrl_decoder.sv
// Combinational RV32I decode into an issue packet: ALU control, operands, rd, flags.
module alu_ctrl_decoder
  import alu_issue_stage_pkg::*;
#(
  parameter int unsigned LINK_OFFSET = 4
) (
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output issue_pkt_t      pkt
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    pkt    = PKT_RESET;
    pkt.rd = instr[11:7];
    case (opcode)
      OPC_OP: begin
        pkt.a        = rs1_data;
        pkt.b        = rs2_data;
        pkt.alu_ctrl = arith_ctrl(f3, f7 == F7_ALT);
        pkt.illegal  = !((f7 == F7_BASE) ||
                         ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA))));
      end
      OPC_OP_IMM: begin
        pkt.a        = rs1_data;
        pkt.b        = imm;
        pkt.alu_ctrl = arith_ctrl(f3, (f3 == F3_SRL_SRA) && (f7 == F7_ALT));
        pkt.illegal  = ((f3 == F3_SLL) && (f7 != F7_BASE)) ||
                       ((f3 == F3_SRL_SRA) && (f7 != F7_BASE) && (f7 != F7_ALT));
      end
      OPC_LUI: begin
        pkt.alu_ctrl = ALU_CTRL_LUI;
        pkt.b        = imm;
      end
      OPC_AUIPC: begin
        pkt.alu_ctrl = ALU_CTRL_AUIPC;
        pkt.a        = pc;
        pkt.b        = imm;
      end
      OPC_BRANCH: begin
        pkt.a         = rs1_data;
        pkt.b         = rs2_data;
        pkt.rd        = '0;
        pkt.is_branch = 1'b1;
        case (f3)
          F3_BEQ:  pkt.alu_ctrl = ALU_CTRL_BEQ;
          F3_BNE:  pkt.alu_ctrl = ALU_CTRL_BNE;
          F3_BLT:  pkt.alu_ctrl = ALU_CTRL_BLT;
          F3_BGE:  pkt.alu_ctrl = ALU_CTRL_BGE;
          F3_BLTU: pkt.alu_ctrl = ALU_CTRL_BLTU;
          F3_BGEU: pkt.alu_ctrl = ALU_CTRL_BGEU;
          default: pkt.illegal  = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        pkt.a = rs1_data;
        pkt.b = imm;
      end
      OPC_STORE: begin
        pkt.a  = rs1_data;
        pkt.b  = imm;
        pkt.rd = '0;
      end
      OPC_JAL, OPC_JALR: begin
        pkt.a = pc;
        pkt.b = XLEN'(LINK_OFFSET);
      end
      default: pkt.illegal = 1'b1;
    endcase
    // Every illegal encoding collapses to the same neutral ADD 0,0 packet.
    if (pkt.illegal) begin
      pkt         = PKT_RESET;
      pkt.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes an op and holds it in a main entry plus a one-deep
// skid entry so that in_ready can be a registered signal.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int unsigned LINK_OFFSET = 4
) (
  input  logic               clk,
  input  logic               rst,
  alu_issue_stage_if.master  bus
);

  issue_pkt_t dec_pkt;
  issue_pkt_t main_q, main_d;
  issue_pkt_t skid_q, skid_d;
  logic       main_valid_q, main_valid_d;
  logic       skid_valid_q, skid_valid_d;
  logic       in_ready_q, in_ready_d;
  logic       accept;

  alu_ctrl_decoder #(.LINK_OFFSET(LINK_OFFSET)) u_dec (
    .instr    (bus.instr),
    .pc       (bus.pc),
    .rs1_data (bus.rs1_data),
    .rs2_data (bus.rs2_data),
    .imm      (bus.imm),
    .pkt      (dec_pkt)
  );

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    accept       = bus.in_valid & in_ready_q & ~bus.flush;
    if (bus.flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Full: no intake; skid refills main once EX takes the current op.
      if (bus.out_ready) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || bus.out_ready) begin
      main_valid_d = accept;
      if (accept) main_d = dec_pkt;
    end else if (accept) begin
      skid_d       = dec_pkt;
      skid_valid_d = 1'b1;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= PKT_RESET;
      skid_q       <= PKT_RESET;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = main_valid_q;
  assign bus.out_a         = main_q.a;
  assign bus.out_b         = main_q.b;
  assign bus.out_alu_ctrl  = main_q.alu_ctrl;
  assign bus.out_rd        = main_q.rd;
  assign bus.out_is_branch = main_q.is_branch;
  assign bus.out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized bench for alu_issue_stage against a queue-based reference model.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_stage_if bus();

  alu_issue_stage #(.LINK_OFFSET(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  localparam issue_pkt_t M_RST = '{a: 32'h0, b: 32'h0, alu_ctrl: ALU_CTRL_ADD_ADDI,
                                   rd: 5'h0, is_branch: 1'b0, illegal: 1'b0};

  int n_vec = 0;
  int n_err = 0;
  int dut_deliv = 0;
  bit started = 1'b0;

  issue_pkt_t m_q[$];
  issue_pkt_t m_last = M_RST;
  bit         m_inrdy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference decode written from the instruction-set rules.
  function automatic issue_pkt_t m_decode(input logic [31:0] ins, input logic [31:0] pcv,
                                          input logic [31:0] r1, input logic [31:0] r2,
                                          input logic [31:0] im);
    AluControl_t arith [8] = '{ALU_CTRL_ADD_ADDI, ALU_CTRL_SLL, ALU_CTRL_SLT, ALU_CTRL_SLTU,
                               ALU_CTRL_XOR, ALU_CTRL_SRL, ALU_CTRL_OR, ALU_CTRL_AND};
    AluControl_t brs [8]   = '{ALU_CTRL_BEQ, ALU_CTRL_BNE, ALU_CTRL_ADD_ADDI, ALU_CTRL_ADD_ADDI,
                               ALU_CTRL_BLT, ALU_CTRL_BGE, ALU_CTRL_BLTU, ALU_CTRL_BGEU};
    issue_pkt_t p;
    logic [2:0] f3;
    logic [6:0] f7;
    bit bad;
    f3 = ins[14:12];
    f7 = ins[31:25];
    p = M_RST;
    p.rd = ins[11:7];
    bad = 1'b0;
    case (ins[6:0])
      7'h33: begin
        p.a = r1; p.b = r2; p.alu_ctrl = arith[f3];
        bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        if (f7 == 7'h20 && f3 == 3'd0) p.alu_ctrl = ALU_CTRL_SUB;
        if (f7 == 7'h20 && f3 == 3'd5) p.alu_ctrl = ALU_CTRL_SRA;
      end
      7'h13: begin
        p.a = r1; p.b = im; p.alu_ctrl = arith[f3];
        if (f3 == 3'd1) bad = (f7 != 7'h00);
        if (f3 == 3'd5) begin
          bad = (f7 != 7'h00) && (f7 != 7'h20);
          if (f7 == 7'h20) p.alu_ctrl = ALU_CTRL_SRA;
        end
      end
      7'h37: begin p.alu_ctrl = ALU_CTRL_LUI; p.b = im; end
      7'h17: begin p.alu_ctrl = ALU_CTRL_AUIPC; p.a = pcv; p.b = im; end
      7'h63: begin
        p.a = r1; p.b = r2; p.rd = 5'd0; p.is_branch = 1'b1;
        p.alu_ctrl = brs[f3]; bad = (f3 == 3'd2) || (f3 == 3'd3);
      end
      7'h03: begin p.a = r1; p.b = im; end
      7'h23: begin p.a = r1; p.b = im; p.rd = 5'd0; end
      7'h6F, 7'h67: begin p.a = pcv; p.b = 32'd4; end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      p = M_RST;
      p.illegal = 1'b1;
    end
    return p;
  endfunction

  // Model state advance at the clock edge, using the inputs held across it.
  task automatic model_update();
    bit acc;
    if (rst) begin
      m_q.delete();
      m_last  = M_RST;
      m_inrdy = 1'b0;
    end else if (bus.flush) begin
      m_q.delete();
      m_inrdy = 1'b1;
    end else begin
      acc = bus.in_valid && m_inrdy;
      if (m_q.size() > 0 && bus.out_ready) void'(m_q.pop_front());
      if (acc) m_q.push_back(m_decode(bus.instr, bus.pc, bus.rs1_data, bus.rs2_data, bus.imm));
      m_inrdy = (m_q.size() < 2);
    end
    if (m_q.size() > 0) m_last = m_q[0];
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pcv,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im);
    bus.in_valid = v; bus.instr = ins; bus.pc = pcv;
    bus.rs1_data = r1; bus.rs2_data = r2; bus.imm = im;
  endtask

  // Cycle-by-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    issue_pkt_t e;
    bit ev;
    if (started) begin
      ev = (m_q.size() > 0);
      e  = ev ? m_q[0] : m_last;
      n_vec++;
      chk("out_valid", 32'(bus.out_valid), 32'(ev));
      chk("in_ready", 32'(bus.in_ready), 32'(m_inrdy));
      chk("out_a", bus.out_a, e.a);
      chk("out_b", bus.out_b, e.b);
      chk("out_alu_ctrl", 32'(bus.out_alu_ctrl), 32'(e.alu_ctrl));
      chk("out_rd", 32'(bus.out_rd), 32'(e.rd));
      chk("out_is_branch", 32'(bus.out_is_branch), 32'(e.is_branch));
      chk("out_illegal", 32'(bus.out_illegal), 32'(e.illegal));
      if (bus.out_valid && bus.out_ready) dut_deliv++;
    end
  end

  initial begin
    logic [6:0] opcs [10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h63, 7'h03, 7'h23, 7'h6F, 7'h67, 7'h7F};
    int idx;
    int d0;
    bit acc_pre;
    logic [31:0] ins;

    bus.flush = 1'b0; bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    // Model pins: hand-decoded expectations.
    chk("model_srai", 32'(m_decode(32'h4040D093, 0, 0, 0, 0).alu_ctrl), 32'(ALU_CTRL_SRA));
    chk("model_bltu_rd", 32'(m_decode(32'h0020E463, 0, 0, 0, 0).rd), 32'd0);

    // Reset
    tick();
    started = 1'b1;
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_alu_ctrl", 32'(bus.out_alu_ctrl), 32'(ALU_CTRL_ADD_ADDI));
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // ADD x3, x1, x2
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 32'h0);
    tick();
    chk("add_valid", 32'(bus.out_valid), 32'd1);
    chk("add_ctrl", 32'(bus.out_alu_ctrl), 32'(ALU_CTRL_ADD_ADDI));
    chk("add_a", bus.out_a, 32'd5);
    chk("add_b", bus.out_b, 32'd7);
    chk("add_rd", 32'(bus.out_rd), 32'd3);

    // SRAI / SRLI / bad funct7
    drive(1'b1, 32'h4040D093, 32'h0, 32'h11, 32'h22, 32'h404);
    tick();
    chk("srai_ctrl", 32'(bus.out_alu_ctrl), 32'(ALU_CTRL_SRA));
    chk("srai_b", bus.out_b, 32'h404);
    drive(1'b1, 32'h0040D093, 32'h0, 32'h11, 32'h22, 32'h4);
    tick();
    chk("srli_ctrl", 32'(bus.out_alu_ctrl), 32'(ALU_CTRL_SRL));
    drive(1'b1, 32'h6040D093, 32'h0, 32'h11, 32'h22, 32'h604);
    tick();
    chk("badshift_illegal", 32'(bus.out_illegal), 32'd1);
    bus.in_valid = 1'b0;
    tick(); tick();

    // Backpressure: 4 ops, EX stalls for 4 cycles
    idx = 0;
    d0 = dut_deliv;
    for (int c = 0; c < 12; c++) begin
      bus.out_ready = !(c >= 1 && c <= 4);
      drive(idx < 4, 32'h002081B3, 32'h0, 32'(idx + 1), $urandom, 32'h0);
      acc_pre = bus.in_valid && m_inrdy;
      tick();
      if (acc_pre) idx++;
      if (c == 1) chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      if (c == 3) chk("bp_held_a", bus.out_a, 32'd1);
    end
    chk("bp_delivered", 32'(dut_deliv - d0), 32'd4);

    // Branch and AUIPC
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h0020E463, 32'h0, 32'h3, 32'h9, 32'h8);
    tick();
    chk("bltu_ctrl", 32'(bus.out_alu_ctrl), 32'(ALU_CTRL_BLTU));
    chk("bltu_is_branch", 32'(bus.out_is_branch), 32'd1);
    chk("bltu_rd", 32'(bus.out_rd), 32'd0);
    drive(1'b1, 32'h00002097, 32'h1000, 32'h55, 32'h66, 32'h2000);
    tick();
    chk("auipc_a", bus.out_a, 32'h1000);
    chk("auipc_b", bus.out_b, 32'h2000);
    bus.in_valid = 1'b0;
    tick();

    // Flush with skid full
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'h0, 32'h1, 32'h2, 32'h0); tick();
    drive(1'b1, 32'h002081B3, 32'h0, 32'h3, 32'h4, 32'h0); tick();
    bus.flush = 1'b1;
    drive(1'b1, 32'h00002097, 32'hDEAD0, 32'h0, 32'h0, 32'hBEEF);
    tick();
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("flush_drop_valid", 32'(bus.out_valid), 32'd0);
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    chk("flush_after_valid", 32'(bus.out_valid), 32'd0);

    // Reset mid-stall, then an illegal opcode
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h002081B3, 32'h0, 32'h7, 32'h8, 32'h0); tick();
    drive(1'b1, 32'h002081B3, 32'h0, 32'h9, 32'hA, 32'h0); tick();
    rst = 1'b1; bus.in_valid = 1'b0;
    tick();
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    tick();
    chk("midrst_after_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_after_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h0000007F, 32'h400, 32'h1234, 32'h5678, 32'h9);
    tick();
    chk("illegal_flag", 32'(bus.out_illegal), 32'd1);
    chk("illegal_a", bus.out_a, 32'd0);
    chk("illegal_b", bus.out_b, 32'd0);
    bus.in_valid = 1'b0;
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      ins = $urandom;
      ins[6:0] = opcs[$urandom_range(0, 9)];
      case ($urandom_range(0, 3))
        0: ins[31:25] = 7'h00;
        1: ins[31:25] = 7'h20;
        default: ;
      endcase
      if ($urandom_range(0, 15) == 0) ins[1:0] = 2'($urandom_range(0, 2));
      drive($urandom_range(0, 9) < 7, ins, $urandom, $urandom, $urandom, $urandom);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.flush     = ($urandom_range(0, 24) == 0);
      rst           = ($urandom_range(0, 199) == 0);
      tick();
    end

    rst = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
